// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
package adder_arb_pkg;

  localparam int unsigned ADDER_W  = 32;
  // Widest id needed for up to 16 requesters; the top slices it down to ID_W.
  localparam int unsigned ID_MAX_W = 4;

  typedef enum logic {
    Arb,
    Locked
  } state_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [ADDER_W-1:0]  sum;
    logic                carry;
  } rsp_t;

endpackage

// File: rtl/adder_arbiter_rr_if.sv
// Request, shared-adder and response signals of adder_arbiter_rr.
interface adder_arbiter_rr_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
  import adder_arb_pkg::*;

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ*ADDER_W-1:0] req_op1_i;
  logic [NUM_REQ*ADDER_W-1:0] req_op2_i;
  logic [NUM_REQ-1:0]         req_carry_i;
  logic [NUM_REQ-1:0]         req_chain_i;
  logic [ADDER_W-1:0]         add_op1_o;
  logic [ADDER_W-1:0]         add_op2_o;
  logic                       add_carry_o;
  logic [ADDER_W-1:0]         add_sum_i;
  logic                       add_carry_i;
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [ID_W-1:0]            rsp_id_o;
  logic [ADDER_W-1:0]         rsp_sum_o;
  logic                       rsp_carry_o;

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, req_carry_i, req_chain_i,
    input  add_sum_i, add_carry_i, rsp_ready_i,
    output req_ready_o, add_op1_o, add_op2_o, add_carry_o,
    output rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o
  );

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, req_carry_i, req_chain_i,
    output add_sum_i, add_carry_i, rsp_ready_i,
    input  req_ready_o, add_op1_o, add_op2_o, add_carry_o,
    input  rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = ID_W'((int'(ptr_i) + i) % int'(NUM_REQ));
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter_rr.sv
// Round-robin scheduler sharing one external 32-bit adder among NUM_REQ requesters.
// Define ADDER_ARB_CHAIN_EN to let a requester lock the adder for chained-carry beats.
module adder_arbiter_rr
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  adder_arbiter_rr_if.slave bus
);

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    sel_idx, mux_idx;
  logic [NUM_REQ-1:0] ready;
  logic               free, acc;
  rsp_t               rsp_q;
  logic               rsp_valid_q;
  logic               unused_id;

`ifdef ADDER_ARB_CHAIN_EN
  state_e          state_q;
  logic [ID_W-1:0] owner_q;
  logic            carry_q;
`else
  logic            unused_chain;
  assign unused_chain = ^bus.req_chain_i;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i (bus.req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    free    = !rsp_valid_q || bus.rsp_ready_i;
    ready   = '0;
    sel_idx = pick_idx;
`ifdef ADDER_ARB_CHAIN_EN
    if (state_q == Locked) begin
      sel_idx        = owner_q;
      ready[owner_q] = free && bus.req_valid_i[owner_q];
    end else if (pick_any && free) begin
      ready = pick_gnt;
    end
`else
    if (pick_any && free) ready = pick_gnt;
`endif
    acc     = |ready;
    mux_idx = acc ? sel_idx : '0;
    ptr_d   = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

    bus.add_op1_o = bus.req_op1_i[mux_idx*ADDER_W +: ADDER_W];
    bus.add_op2_o = bus.req_op2_i[mux_idx*ADDER_W +: ADDER_W];
`ifdef ADDER_ARB_CHAIN_EN
    // Continuation beats take the carry left by the owner's previous beat.
    bus.add_carry_o = (state_q == Locked) ? carry_q : bus.req_carry_i[mux_idx];
`else
    bus.add_carry_o = bus.req_carry_i[mux_idx];
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ADDER_ARB_CHAIN_EN
      state_q     <= Arb;
      owner_q     <= '0;
      carry_q     <= 1'b0;
`endif
    end else if (acc) begin
      rsp_q.id    <= ID_MAX_W'(sel_idx);
      rsp_q.sum   <= bus.add_sum_i;
      rsp_q.carry <= bus.add_carry_i;
      rsp_valid_q <= 1'b1;
      ptr_q       <= ptr_d;
`ifdef ADDER_ARB_CHAIN_EN
      carry_q     <= bus.add_carry_i;
      owner_q     <= sel_idx;
      state_q     <= bus.req_chain_i[sel_idx] ? Locked : Arb;
`endif
    end else if (bus.rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = rsp_q.id[ID_W-1:0];
  assign bus.rsp_sum_o   = rsp_q.sum;
  assign bus.rsp_carry_o = rsp_q.carry;
  assign unused_id       = ^rsp_q.id;

endmodule

// File: tb/tb_adder_arbiter_rr.sv
// Scoreboard bench for adder_arbiter_rr with a behavioural shared adder.
module tb_adder_arbiter_rr;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   sum;
    logic          carry;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  adder_arbiter_rr_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  adder_arbiter_rr #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign {bus.add_carry_i, bus.add_sum_i} =
    {1'b0, bus.add_op1_o} + {1'b0, bus.add_op2_o} + 33'(bus.add_carry_o);

  function automatic exp_t mk(int k, logic [31:0] a, logic [31:0] b, logic c);
    exp_t   r;
    logic [32:0] s;
    s       = {1'b0, a} + {1'b0, b} + 33'(c);
    r.id    = IW'(k);
    r.sum   = s[31:0];
    r.carry = s[32];
    return r;
  endfunction

  task automatic set_req(int k, logic v, logic [31:0] a, logic [31:0] b, logic c, logic ch);
    bus.req_valid_i[k]        = v;
    bus.req_op1_i[k*32 +: 32] = a;
    bus.req_op2_i[k*32 +: 32] = b;
    bus.req_carry_i[k]        = c;
    bus.req_chain_i[k]        = ch;
  endtask

  task automatic clear_req();
    bus.req_valid_i = '0;
    bus.req_op1_i   = '0;
    bus.req_op2_i   = '0;
    bus.req_carry_i = '0;
    bus.req_chain_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_req();
    bus.rsp_ready_i = 1'b1;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b id=%0d sum=%h c=%b, required all zero",
               bus.rsp_valid_o, bus.req_ready_o, bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o);
    end
    checks++;
    if ({bus.add_op1_o, bus.add_op2_o, bus.add_carry_o} !== '0) begin
      errors++;
      $display("FAIL reset_adder: op1=%h op2=%h c=%b, required zero",
               bus.add_op1_o, bus.add_op2_o, bus.add_carry_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b required 0100", bus.req_ready_o);
    end
    sb.push_back(mk(2, 32'hFFFF_FFFF, 32'h1, 1'b0));
    @(posedge clk); #1;
    clear_req();
    checks++;
    if (!bus.rsp_valid_o || sb.size() == 0) begin
      errors++;
      $display("FAIL single_valid: got valid=%b required 1", bus.rsp_valid_o);
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== {e.id, e.sum, e.carry}) begin
        errors++;
        $display("FAIL single_rsp: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b",
                 bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o, e.id, e.sum, e.carry);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got valid=%b required 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    int k;
    do_reset();
    for (int i = 0; i < int'(N); i++)
      set_req(i, 1'b1, 32'hF000_0000 + i, 32'h1000_0000 * (i + 1), i[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      k = c % int'(N);
      exp_rdy = N'(1) << k;
      #1;
      checks++;
      if (bus.req_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b required %b", c, bus.req_ready_o, exp_rdy);
      end
      sb.push_back(mk(k, 32'hF000_0000 + k, 32'h1000_0000 * (k + 1), k[0]));
      @(posedge clk); #1;
      checks++;
      if (!bus.rsp_valid_o || sb.size() == 0) begin
        errors++;
        $display("FAIL rr_valid%0d: got valid=%b required 1", c, bus.rsp_valid_o);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== {e.id, e.sum, e.carry}) begin
          errors++;
          $display("FAIL rr_rsp%0d: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b", c,
                   bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o, e.id, e.sum, e.carry);
        end
      end
    end
    clear_req();
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_req(0, 1'b1, 32'h1000, 32'h234, 1'b0, 1'b0);
    sb.push_back(mk(0, 32'h1000, 32'h234, 1'b0));
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 32'h10 * i, 32'h5, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready_o !== '0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_sum_o !== 32'h1234 ||
          bus.rsp_id_o !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: got ready=%b valid=%b sum=%h id=%0d required 0000/1/1234/0",
                 c, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_sum_o, bus.rsp_id_o);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b required 0010", bus.req_ready_o);
    end
    checks++;
    if (sb.size() == 0 || !bus.rsp_valid_o) begin
      errors++;
      $display("FAIL bp_deliver: got valid=%b required 1", bus.rsp_valid_o);
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== {e.id, e.sum, e.carry}) begin
        errors++;
        $display("FAIL bp_rsp: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b",
                 bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o, e.id, e.sum, e.carry);
      end
    end
    sb.push_back(mk(1, 32'h10, 32'h5, 1'b0));
    @(posedge clk); #1;
    clear_req();
    checks++;
    if (sb.size() == 0 || !bus.rsp_valid_o) begin
      errors++;
      $display("FAIL bp_overwrite: got valid=%b required 1", bus.rsp_valid_o);
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== {e.id, e.sum, e.carry}) begin
        errors++;
        $display("FAIL bp_overwrite_rsp: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b",
                 bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o, e.id, e.sum, e.carry);
      end
    end
  endtask

`ifdef ADDER_ARB_CHAIN_EN
  task automatic test_chain();
    logic [N-1:0] exp_rdy [4] = '{4'b0010, 4'b0000, 4'b0010, 4'b0001};
    do_reset();
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    sb.push_back('{id: 2'd1, sum: 32'h0, carry: 1'b1});
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.req_ready_o !== exp_rdy[c]) begin
        errors++;
        $display("FAIL chain_ready%0d: got %b required %b", c, bus.req_ready_o, exp_rdy[c]);
      end
      @(posedge clk); #1;
      if (c != 1) begin
        checks++;
        if (sb.size() == 0 || !bus.rsp_valid_o) begin
          errors++;
          $display("FAIL chain_valid%0d: got valid=%b required 1", c, bus.rsp_valid_o);
        end else begin
          e = sb.pop_front();
          if ({bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== {e.id, e.sum, e.carry}) begin
            errors++;
            $display("FAIL chain_rsp%0d: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b", c,
                     bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o, e.id, e.sum, e.carry);
          end
        end
      end
      case (c)
        0: begin  // owner stalls while req 0 waits
          set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
          set_req(0, 1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
        end
        1: begin
          set_req(1, 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
          sb.push_back('{id: 2'd1, sum: 32'h2, carry: 1'b0});
        end
        2: begin
          set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
          sb.push_back('{id: 2'd0, sum: 32'h30, carry: 1'b0});
        end
        default: clear_req();
      endcase
    end
  endtask
`else
  task automatic test_no_chain();
    do_reset();
    set_req(1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
    set_req(2, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.req_ready_o !== ((c == 0) ? 4'b0010 : 4'b0100)) begin
        errors++;
        $display("FAIL nochain_ready%0d: got %b required %b", c, bus.req_ready_o,
                 (c == 0) ? 4'b0010 : 4'b0100);
      end
      sb.push_back((c == 0) ? '{id: 2'd1, sum: 32'h1, carry: 1'b0} :
                              '{id: 2'd2, sum: 32'hB, carry: 1'b0});
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0 || !bus.rsp_valid_o) begin
        errors++;
        $display("FAIL nochain_valid%0d: got valid=%b required 1", c, bus.rsp_valid_o);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o} !== {e.id, e.sum, e.carry}) begin
          errors++;
          $display("FAIL nochain_rsp%0d: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b", c,
                   bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_carry_o, e.id, e.sum, e.carry);
        end
      end
    end
    clear_req();
  endtask
`endif

  task automatic test_reset_mid_chain();
    do_reset();
    set_req(1, 1'b1, 32'h7, 32'h8, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: got valid=%b required 1", bus.rsp_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: got valid=%b required 0", bus.rsp_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    set_req(0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_arb: got ready=%b required 0001", bus.req_ready_o);
    end
    @(posedge clk); #1;
    clear_req();
  endtask

  initial begin
    clear_req();
    bus.rsp_ready_i = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
`ifdef ADDER_ARB_CHAIN_EN
    test_chain();
`else
    test_no_chain();
`endif
    test_reset_mid_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
